// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues pipelined word fetches and
// buffers returned instructions in a small FIFO whose head feeds ID.
// Redirects flush the FIFO and mark in-flight fetches stale so they are dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ready,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_pipe_ready,
    input  logic        id_pipe_flush,
    output logic        id_pipe_valid,
    output logic [31:0] id_pipe_pc,
    output logic [31:0] id_pipe_instruction
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   kill_cnt_q;
    logic [CW-1:0]   fifo_cnt_q;

    // In-order queue of issued addresses; every response retires one entry
    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [PW-1:0]   tag_wptr_q;
    logic [PW-1:0]   tag_rptr_q;

    // Response FIFO storage (head drives the ID pipeline)
    logic [XLEN-1:0] fifo_pc  [DEPTH];
    logic [XLEN-1:0] fifo_ins [DEPTH];
    logic [PW-1:0]   fifo_wptr_q;
    logic [PW-1:0]   fifo_rptr_q;

    logic            flush_c;
    logic            pop_c;
    logic            rsp_c;
    logic            issue_c;
    logic            push_c;
    logic [CW:0]     credit_c;
    logic [XLEN-1:0] redirect_aligned_c;

    // Handshake decode and issue credit check
    always_comb begin
        flush_c            = redirect | id_pipe_flush;
        pop_c              = id_pipe_valid & id_pipe_ready;
        rsp_c              = ibus_rvalid & ~rst;
        redirect_aligned_c = redirect_pc & ~XLEN'(3);
        // live in-flight fetches plus buffered words, minus the one leaving this cycle
        credit_c           = {1'b0, outstanding_q} - {1'b0, kill_cnt_q}
                           + {1'b0, fifo_cnt_q} - (CW+1)'(pop_c);
        ibus_req           = ~rst & ~flush_c
                           & (credit_c < (CW+1)'(DEPTH))
                           & (outstanding_q < CW'(DEPTH));
        issue_c            = ibus_req & ibus_ready;
        push_c             = rsp_c & ~flush_c & (kill_cnt_q == '0);
    end

    assign ibus_addr           = pc_q;
    assign id_pipe_valid       = (fifo_cnt_q != '0);
    assign id_pipe_pc          = fifo_pc[fifo_rptr_q];
    assign id_pipe_instruction = fifo_ins[fifo_rptr_q];

    // PC, counters and pointers; a redirect overrides the normal fifo/kill update
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            tag_wptr_q    <= '0;
            tag_rptr_q    <= '0;
            fifo_wptr_q   <= '0;
            fifo_rptr_q   <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(issue_c) - CW'(rsp_c);
            if (rsp_c) begin
                tag_rptr_q <= tag_rptr_q + PW'(1);
            end
            if (issue_c) begin
                tag_wptr_q <= tag_wptr_q + PW'(1);
                pc_q       <= pc_q + XLEN'(4);
            end
            if (flush_c) begin
                pc_q        <= redirect_aligned_c;
                // everything still in flight after this cycle is stale
                kill_cnt_q  <= outstanding_q - CW'(rsp_c);
                fifo_cnt_q  <= '0;
                fifo_wptr_q <= '0;
                fifo_rptr_q <= '0;
            end else begin
                if (rsp_c && (kill_cnt_q != '0)) begin
                    kill_cnt_q <= kill_cnt_q - CW'(1);
                end
                if (push_c) begin
                    fifo_wptr_q <= fifo_wptr_q + PW'(1);
                end
                if (pop_c) begin
                    fifo_rptr_q <= fifo_rptr_q + PW'(1);
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // Address tag and response data storage, no reset needed
    always_ff @(posedge clk) begin
        if (issue_c) begin
            tag_mem[tag_wptr_q] <= pc_q;
        end
        if (push_c) begin
            fifo_pc[fifo_wptr_q]  <= tag_mem[tag_rptr_q];
            fifo_ins[fifo_wptr_q] <= ibus_rdata;
        end
    end

    // Structural invariants of the credit scheme
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_overflow:   assert (!(push_c && !pop_c && (fifo_cnt_q == CW'(DEPTH))));
            a_kill_bound:    assert (kill_cnt_q <= outstanding_q);
            a_no_spurious:   assert (!(rsp_c && (outstanding_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order ibus model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_pipe_ready;
    logic        id_pipe_flush;
    logic        id_pipe_valid;
    logic [31:0] id_pipe_pc;
    logic [31:0] id_pipe_instruction;

    fetch_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .ibus_req            (ibus_req),
        .ibus_addr           (ibus_addr),
        .ibus_ready          (ibus_ready),
        .ibus_rvalid         (ibus_rvalid),
        .ibus_rdata          (ibus_rdata),
        .redirect            (redirect),
        .redirect_pc         (redirect_pc),
        .id_pipe_ready       (id_pipe_ready),
        .id_pipe_flush       (id_pipe_flush),
        .id_pipe_valid       (id_pipe_valid),
        .id_pipe_pc          (id_pipe_pc),
        .id_pipe_instruction (id_pipe_instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        last_rsp = 1'b0;
    logic        last_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock cycle: entered and left at the negedge
    task automatic step();
        req_t r;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem_word(pend[0].addr);
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        last_rsp   = ibus_rvalid;
        last_valid = id_pipe_valid;
        if (!rst && id_pipe_valid && id_pipe_ready && !redirect && !id_pipe_flush) begin
            check("id_pc", id_pipe_pc, exp_pc);
            check("id_instr", id_pipe_instruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (ibus_req && ibus_ready) begin
            r.addr = ibus_addr;
            r.due  = cyc + lat;
            pend.push_back(r);
            req_cnt++;
        end
        @(posedge clk);
        cyc++;
        if (ibus_rvalid) pend.delete(0);
        if (rst) pend.delete();
        if (!rst && (redirect || id_pipe_flush)) exp_pc = redirect_pc & ~32'd3;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        redirect      = 1'b0;
        id_pipe_flush = 1'b0;
        id_pipe_ready = 1'b0;
        ibus_ready    = 1'b1;
        lat           = 1;
        repeat (3) step();
        check("rst_req", 32'(ibus_req), 32'd0);
        check("rst_valid", 32'(id_pipe_valid), 32'd0);
        pend.delete();
        rst    = 1'b0;
        exp_pc = 32'h0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ibus_ready = 1'b1; ibus_rvalid = 1'b0; ibus_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_pipe_ready = 1'b0; id_pipe_flush = 1'b0;
        @(negedge clk);

        // Reset release, streaming one instruction per cycle
        do_reset();
        id_pipe_ready = 1'b1;
        #1;
        check("t1_first_req", 32'(ibus_req), 32'd1);
        check("t1_first_addr", ibus_addr, 32'h0);
        step();
        check("t1_valid_c1", 32'(id_pipe_valid), 32'd0);
        step();
        check("t1_valid_c2", 32'(id_pipe_valid), 32'd1);
        check("t1_head_pc", id_pipe_pc, 32'h0);
        pop_cnt = 0;
        repeat (10) step();
        check("t1_rate", 32'(pop_cnt), 32'd10);

        // ID stalled: FIFO fills with two words, then drains in order
        do_reset();
        req_cnt = 0;
        repeat (10) step();
        check("t2_reqs", 32'(req_cnt), 32'd2);
        check("t2_full_valid", 32'(id_pipe_valid), 32'd1);
        check("t2_full_noreq", 32'(ibus_req), 32'd0);
        check("t2_head_pc", id_pipe_pc, 32'h0);
        id_pipe_ready = 1'b1;
        pop_cnt = 0;
        repeat (6) step();
        check("t2_pops", 32'(pop_cnt), 32'd6);

        // Redirect with two fetches outstanding (latency 3)
        do_reset();
        lat = 3;
        id_pipe_ready = 1'b1;
        repeat (2) step();
        do_redirect(32'h100);
        check("t3_addr", ibus_addr, 32'h100);
        check("t3_valid", 32'(id_pipe_valid), 32'd0);
        check("t3_noreq", 32'(ibus_req), 32'd0);
        pop_cnt = 0;
        repeat (12) step();
        check("t3_progress", 32'(pop_cnt >= 2), 32'd1);

        // Redirect coinciding with a response and a pop; then back-to-back redirects
        do_reset();
        id_pipe_ready = 1'b1;
        repeat (5) step();
        do_redirect(32'h300);
        check("t4_rsp_same_cycle", 32'(last_rsp), 32'd1);
        check("t4_valid_same_cycle", 32'(last_valid), 32'd1);
        pop_cnt = 0;
        repeat (8) step();
        check("t4_pops", 32'(pop_cnt), 32'd6);
        redirect = 1'b1; redirect_pc = 32'h400;
        step();
        id_pipe_flush = 1'b1; redirect_pc = 32'h500;
        step();
        redirect = 1'b0; id_pipe_flush = 1'b0;
        pop_cnt = 0;
        repeat (8) step();
        check("t4_b2b_pops", 32'(pop_cnt), 32'd6);

        // Misaligned redirect target and PC wrap-around
        do_redirect(32'h203);
        check("t6_aligned_addr", ibus_addr, 32'h200);
        pop_cnt = 0;
        repeat (8) step();
        check("t6_aligned_pops", 32'(pop_cnt), 32'd6);
        do_redirect(32'hFFFF_FFF4);
        pop_cnt = 0;
        repeat (8) step();
        check("t6_wrap_pops", 32'(pop_cnt), 32'd6);
        check("t6_wrap_addr", ibus_addr, 32'h0000_0014);

        // Random bus stalls, latency 1..3, ID stalls and occasional redirects
        do_reset();
        pop_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            ibus_ready    = ($urandom_range(0, 3) != 0);
            lat           = int'($urandom_range(1, 3));
            id_pipe_ready = ($urandom_range(0, 2) != 0);
            redirect      = ($urandom_range(0, 39) == 0);
            redirect_pc   = $urandom;
            step();
        end
        redirect = 1'b0; ibus_ready = 1'b1; id_pipe_ready = 1'b1; lat = 1;
        repeat (20) step();
        check("t5_progress", 32'(pop_cnt > 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
